coin_pulse_conditioner: RTL

Front-end stage feeding the vending-machine FSM. Turns raw, bouncy, asynchronous nickel/dime sensor levels into clean single-cycle N and D pulses. N and D are never high in the same cycle, because the FSM treats N&D as "no coin". When the downstream block reports the door open, coins are rejected instead.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/coin_pulse_conditioner_if.sv | 33 +++
 rtl/coin_debounce.sv | 51 +++++
 rtl/coin_pulse_conditioner.sv | 98 +++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// ============================================================================
// Module  : vend_pkg
// Brief   : Coin values and vending-FSM state encoding shared by the coin
//           front end, the vending FSM and their benches.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

  localparam logic [15:0] NICKEL_CENTS = 16'd5;
  localparam logic [15:0] DIME_CENTS   = 16'd10;

  typedef enum logic [1:0] {
    ZERO    = 2'd0,
    FIVE    = 2'd1,
    TEN     = 2'd2,
    FIFTEEN = 2'd3
  } vend_state_t;

  function automatic logic [15:0] coin_cents(input logic nickel, input logic dime);
    if (nickel)
      return NICKEL_CENTS;
    else if (dime)
      return DIME_CENTS;
    else
      return 16'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coin_pulse_conditioner_if.sv
// ============================================================================
// Module  : coin_pulse_conditioner_if
// Brief   : Sensor, accept and credit-pulse bundle between the coin front end
//           and its neighbours. COIN_TOTAL_EN adds the running total_cents.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface coin_pulse_conditioner_if;

  logic        nickel_raw;
  logic        dime_raw;
  logic        accept;
  logic        N;
  logic        D;
  logic        reject;
`ifdef COIN_TOTAL_EN
  logic [15:0] total_cents;

  modport master (output nickel_raw, dime_raw, accept,
                  input  N, D, reject, total_cents);
  modport slave  (input  nickel_raw, dime_raw, accept,
                  output N, D, reject, total_cents);
`else
  modport master (output nickel_raw, dime_raw, accept,
                  input  N, D, reject);
  modport slave  (input  nickel_raw, dime_raw, accept,
                  output N, D, reject);
`endif

endinterface

`default_nettype wire

// File: rtl/coin_debounce.sv
// ============================================================================
// Module  : coin_debounce
// Brief   : One sensor channel: 2-FF synchronizer, hold-time debounce counter,
//           stable level register and a pulse announcing a 0->1 acceptance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // High in the cycle whose closing edge raises the stable level.
  assign rise = r_sync2 & ~r_stable & (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/coin_pulse_conditioner.sv
// ============================================================================
// Module  : coin_pulse_conditioner
// Brief   : Debounced nickel/dime sensors to exclusive one-cycle N/D credit
//           pulses, with reject pulses while accept is low.
//           Optional macro COIN_TOTAL_EN adds a running total_cents counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_pulse_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  coin_pulse_conditioner_if.slave  bus
);

  logic w_n_rise;
  logic w_d_rise;
  logic w_n_set;
  logic w_d_set;
  logic w_n_issue;
  logic w_d_issue;

  logic r_n_pend;
  logic r_d_pend;
  logic r_rej_pend;
  logic r_n;
  logic r_d;
  logic r_reject;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_nickel (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.nickel_raw),
    .rise  (w_n_rise)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_dime (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.dime_raw),
    .rise  (w_d_rise)
  );

  assign w_n_set   = w_n_rise & bus.accept;
  assign w_d_set   = w_d_rise & bus.accept;
  // Nickel wins arbitration; a dime waits behind it for one cycle.
  assign w_n_issue = r_n_pend;
  assign w_d_issue = ~r_n_pend & r_d_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_pend   <= 1'b0;
      r_d_pend   <= 1'b0;
      r_rej_pend <= 1'b0;
      r_n        <= 1'b0;
      r_d        <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_n_pend   <= (r_n_pend & ~w_n_issue) | w_n_set;
      r_d_pend   <= (r_d_pend & ~w_d_issue) | w_d_set;
      r_rej_pend <= (w_n_rise | w_d_rise) & ~bus.accept;
      r_reject   <= r_rej_pend;
      r_n        <= w_n_issue;
      r_d        <= w_d_issue;
    end
  end

  assign bus.N      = r_n;
  assign bus.D      = r_d;
  assign bus.reject = r_reject;

`ifdef COIN_TOTAL_EN
  logic [15:0] r_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_total <= 16'd0;
    else
      r_total <= r_total + coin_cents(w_n_issue, w_d_issue);
  end

  assign bus.total_cents = r_total;
`endif

endmodule

`default_nettype wire
